stepper_ramp_ctrl: RTL and testbench

STEPPER_RAMP_CTRL -- requirements
Module: stepper_ramp_ctrl

---
 rtl/stepper_pkg.sv | 22 ++
 rtl/ir_sync_edge.sv | 35 +++
 rtl/stepper_ramp_ctrl.sv | 150 +++++++++++++++
 tb/tb_stepper_ramp_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - state encoding and default parameters for the stepper ramp controller
package stepper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL
  } state_t;

  localparam int DEF_N_IR          = 3;
  localparam bit DEF_IR_ACTIVE_LOW = 1'b1;
  localparam int DEF_PERIOD_W      = 16;
  localparam int DEF_MAX_PERIOD    = 1500;
  localparam int DEF_MIN_PERIOD    = 300;
  localparam int DEF_RAMP_DEC      = 20;
  localparam int DEF_PULSE_W       = 50;
  localparam int DEF_DIR_SETUP     = 100;
  localparam int DEF_CNT_W         = 32;

endpackage

// File: rtl/ir_sync_edge.sv
// rtl/ir_sync_edge.sv - two-flop synchroniser with polarity normalisation and edge detect
module ir_sync_edge #(
  parameter int N          = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pin,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  // Raw pin value that means "sensor not active"; the sync flops reset to it.
  localparam logic [N-1:0] IDLE_PIN = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

  logic [N-1:0] s1, s2, level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= IDLE_PIN;
      s2      <= IDLE_PIN;
      level_q <= '0;
    end else begin
      s1      <= pin;
      s2      <= s1;
      level_q <= level;
    end
  end

  assign level = s2 ^ IDLE_PIN;
  assign rise  = level & ~level_q;
  assign fall  = ~level & level_q;

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// rtl/stepper_ramp_ctrl.sv - trapezoidal-ramp stepper pulse generator with limit and mark sensing
module stepper_ramp_ctrl
  import stepper_pkg::*;
#(
  parameter int N_IR          = DEF_N_IR,
  parameter bit IR_ACTIVE_LOW = DEF_IR_ACTIVE_LOW,
  parameter int PERIOD_W      = DEF_PERIOD_W,
  parameter int MAX_PERIOD    = DEF_MAX_PERIOD,
  parameter int MIN_PERIOD    = DEF_MIN_PERIOD,
  parameter int RAMP_DEC      = DEF_RAMP_DEC,
  parameter int PULSE_W       = DEF_PULSE_W,
  parameter int DIR_SETUP     = DEF_DIR_SETUP,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [N_IR-1:0]  IR,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_in,
  output logic             STEP,
  output logic             DIR,
  output logic             EN,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] position,
  output logic             mark
);

  localparam logic [PERIOD_W-1:0] P_MAX     = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] P_DEC     = PERIOD_W'(RAMP_DEC);
  localparam logic [PERIOD_W-1:0] P_ONE     = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] SETUP_CNT = PERIOD_W'(DIR_SETUP - 1);
  localparam logic [PERIOD_W-1:0] PULSE_CNT = PERIOD_W'(PULSE_W - 1);
  localparam logic [PERIOD_W:0]   ACC_FLOOR = (PERIOD_W+1)'(MIN_PERIOD + RAMP_DEC);
  localparam logic [CNT_W-1:0]    POS_ONE   = CNT_W'(1);
  localparam logic [N_IR-1:0]     MARK_MASK = ~(N_IR'(1) | (N_IR'(1) << (N_IR - 1)));

  state_t              state;
  logic [PERIOD_W-1:0] period, cnt, hcnt;
  logic                last;

  logic [N_IR-1:0]     ir_lvl, ir_rise, ir_fall;
  logic                lim_fwd, lim_rev, lim_travel, rise_due, pulse_end;
  logic [PERIOD_W-1:0] cur_p, acc_next, dec_next;
  logic [PERIOD_W:0]   dec_sum;
  logic                acc_min, dec_last;
  logic                unused_ir;

  ir_sync_edge #(
    .N          (N_IR),
    .ACTIVE_LOW (IR_ACTIVE_LOW)
  ) u_ir (
    .clk   (CLK),
    .rst_n (RSTn),
    .pin   (IR),
    .level (ir_lvl),
    .rise  (ir_rise),
    .fall  (ir_fall)
  );

  assign unused_ir = ^{ir_fall, ir_lvl & MARK_MASK};

  // Ramp arithmetic is done one bit wider so neither direction can wrap.
  always_comb begin
    lim_fwd    = ir_lvl[N_IR-1];
    lim_rev    = ir_lvl[0];
    lim_travel = DIR ? lim_fwd : lim_rev;
    rise_due   = (cnt == '0) && !last;
    pulse_end  = STEP && (hcnt == '0);
    cur_p      = (state == ST_SETUP) ? P_MAX : period;
    acc_min    = {1'b0, cur_p} <= ACC_FLOOR;
    acc_next   = acc_min ? P_MIN : cur_p - P_DEC;
    dec_sum    = {1'b0, cur_p} + {1'b0, P_DEC};
    dec_last   = dec_sum >= {1'b0, P_MAX};
    dec_next   = dec_last ? P_MAX : dec_sum[PERIOD_W-1:0];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      STEP     <= 1'b0;
      DIR      <= 1'b0;
      EN       <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      mark     <= 1'b0;
      position <= '0;
      period   <= P_MAX;
      cnt      <= '0;
      hcnt     <= '0;
      last     <= 1'b0;
    end else begin
      mark <= |(ir_rise & MARK_MASK);
      if (cnt != '0) cnt <= cnt - P_ONE;
      // A started pulse always runs its full width, even after motion is aborted.
      if (STEP) begin
        if (hcnt == '0) STEP <= 1'b0;
        else            hcnt <= hcnt - P_ONE;
      end

      if (state == ST_IDLE) begin
        if (start && !stop) begin
          if (dir_in ? lim_fwd : lim_rev) begin
            fault <= 1'b1;
          end else begin
            DIR   <= dir_in;
            EN    <= 1'b1;
            busy  <= 1'b1;
            fault <= 1'b0;
            last  <= 1'b0;
            cnt   <= SETUP_CNT;
            state <= ST_SETUP;
          end
        end
      end else if (lim_travel) begin
        state <= ST_IDLE;
        EN    <= 1'b0;
        busy  <= 1'b0;
        fault <= 1'b1;
      end else if (last && pulse_end) begin
        state <= ST_IDLE;
        EN    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        if (rise_due) begin
          STEP     <= 1'b1;
          hcnt     <= PULSE_CNT;
          cnt      <= cur_p - P_ONE;
          position <= DIR ? position + POS_ONE : position - POS_ONE;
          case (state)
            ST_DECEL: begin
              period <= dec_next;
              last   <= dec_last;
            end
            ST_CRUISE: period <= P_MIN;
            default: begin
              period <= acc_next;
              state  <= acc_min ? ST_CRUISE : ST_ACCEL;
            end
          endcase
        end
        // The rise on this edge still used the old ramp direction.
        if (stop && (state == ST_ACCEL || state == ST_CRUISE)) state <= ST_DECEL;
      end
    end
  end

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// tb/tb_stepper_ramp_ctrl.sv - randomized run/stop/limit bench against a step-schedule model
module tb_stepper_ramp_ctrl;

  localparam int N_IR = 3, MAXP = 10, MINP = 4, DEC = 2, PW = 2, SETUP = 3, CNT_W = 32;
  localparam int RUN_CYC = 110;
  localparam int NEVER = 1 << 30;

  logic CLK = 1'b0;
  logic RSTn;
  logic [N_IR-1:0] IR;
  logic start, stop, dir_in;
  logic STEP, DIR, EN, busy, fault, mark;
  logic [CNT_W-1:0] position;

  stepper_ramp_ctrl #(
    .N_IR(N_IR), .IR_ACTIVE_LOW(1'b1), .PERIOD_W(16), .MAX_PERIOD(MAXP), .MIN_PERIOD(MINP),
    .RAMP_DEC(DEC), .PULSE_W(PW), .DIR_SETUP(SETUP), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .IR(IR), .start(start), .stop(stop), .dir_in(dir_in),
    .STEP(STEP), .DIR(DIR), .EN(EN), .busy(busy), .fault(fault),
    .position(position), .mark(mark)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int rises[$], exp_rises[$], marks[$];
  int en_fall = -1;
  logic step_q = 1'b0, en_q = 1'b0;
  logic [N_IR-1:0] base_act = '0;
  logic [CNT_W-1:0] exp_pos = '0;
  int t0;

  always @(negedge CLK) begin
    if (STEP && !step_q) rises.push_back(cyc);
    if (mark) marks.push_back(cyc);
    if (en_q && !EN) en_fall = cyc;
    step_q = STEP;
    en_q = EN;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Step schedule from the ramp rules: each rise is one period after the last,
  // the period shrinks by DEC (floor MINP) until stop, then grows by DEC; the
  // step whose grown period reaches MAXP is the final one.
  task automatic model(input int ts, input int stop_e, input int lim_a,
                       output int end_e, output bit flt);
    int t, p;
    bit fin;
    exp_rises.delete();
    t = ts + SETUP; p = MAXP; flt = 1'b0; fin = 1'b0; end_e = -1;
    while (!fin && exp_rises.size() < 1000) begin
      if (t >= lim_a) begin
        flt = 1'b1; end_e = lim_a; fin = 1'b1;
      end else begin
        exp_rises.push_back(t);
        if (stop_e > ts + SETUP && stop_e < t) begin
          if (p + DEC >= MAXP) begin
            end_e = t + PW;
            if (lim_a <= end_e) begin end_e = lim_a; flt = 1'b1; end
            fin = 1'b1;
          end else begin
            t = t + p; p = p + DEC;
          end
        end else begin
          t = t + p; p = (p - DEC > MINP) ? p - DEC : MINP;
        end
      end
    end
  endtask

  // Offsets are relative to the start edge; negative means the event is not used.
  task automatic do_run(input bit d, input int stop_off, input int lim_off,
                        input int opp_off, input int mark_off);
    int stop_e, lim_pin, opp_pin, m_pin, end_e;
    bit flt;
    logic [N_IR-1:0] act;
    @(negedge CLK);
    start = 1'b1; dir_in = d; t0 = cyc + 1;
    rises.delete(); marks.delete(); en_fall = -1;
    stop_e  = (stop_off < 0) ? -1 : t0 + stop_off;
    lim_pin = (lim_off < 0) ? NEVER : t0 + lim_off;
    opp_pin = (opp_off < 0) ? NEVER : t0 + opp_off;
    m_pin   = (mark_off < 0) ? NEVER : t0 + mark_off;
    @(negedge CLK);
    start = 1'b0;
    check("en_on", EN, 1);
    check("busy_on", busy, 1);
    check("fault_clr", fault, 0);
    check("dir_latch", DIR, d);
    repeat (RUN_CYC) begin
      act = base_act;
      if (cyc >= lim_pin) act[d ? 2 : 0] = 1'b1;
      if (cyc >= opp_pin) act[d ? 0 : 2] = 1'b1;
      if (cyc >= m_pin && cyc < m_pin + 3) act[1] = 1'b1;
      IR = ~act;
      stop = (cyc + 1 == stop_e);
      @(negedge CLK);
    end
    stop = 1'b0;
    IR = ~base_act;
    model(t0, stop_e, lim_pin + 3, end_e, flt);
    check("n_rise", rises.size(), exp_rises.size());
    for (int i = 0; i < exp_rises.size() && i < rises.size(); i++)
      check("rise_t", rises[i] - t0, exp_rises[i] - t0);
    check("en_fall", en_fall - t0, end_e - t0);
    check("busy_end", busy, 0);
    check("en_end", EN, 0);
    check("fault", fault, flt);
    exp_pos = d ? exp_pos + CNT_W'(exp_rises.size()) : exp_pos - CNT_W'(exp_rises.size());
    check("position", position, exp_pos);
    check("n_mark", marks.size(), (mark_off < 0) ? 0 : 1);
    if (mark_off >= 0 && marks.size() > 0) check("mark_t", marks[0] - t0, mark_off + 3);
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, so, lo, oo, mo;
    bit d;
    int spacing [5] = '{10, 8, 6, 4, 4};
    RSTn = 1'b0; IR = '1; start = 1'b0; stop = 1'b0; dir_in = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_step", STEP, 0);
    check("rst_dir", DIR, 0);
    check("rst_en", EN, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_mark", mark, 0);
    check("rst_pos", position, 0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Forward ramp, stop well into cruise, one mark pulse.
    do_run(1'b1, 40, -1, -1, 20);
    check("first_step", (rises.size() > 0) ? rises[0] - t0 : -1, SETUP);
    check("n_ramp", rises.size() >= 6, 1);
    for (int i = 0; i < 5 && i + 1 < rises.size(); i++)
      check("spacing", rises[i+1] - rises[i], spacing[i]);
    check("pos_eq_steps", position, rises.size());

    // Forward limit trips a fault; reverse start with it still held clears it.
    do_run(1'b1, -1, 30, -1, -1);
    base_act = 3'b100; IR = ~base_act;
    repeat (5) @(negedge CLK);
    check("fault_hold", fault, 1);
    do_run(1'b0, 20, -1, -1, -1);
    base_act = '0; IR = ~base_act;

    // Start into an active reverse limit is rejected.
    base_act = 3'b001; IR = ~base_act;
    repeat (5) @(negedge CLK);
    rises.delete();
    start = 1'b1; dir_in = 1'b0;
    @(negedge CLK); start = 1'b0;
    repeat (10) @(negedge CLK);
    check("rej_en", EN, 0);
    check("rej_busy", busy, 0);
    check("rej_fault", fault, 1);
    check("rej_steps", rises.size(), 0);
    base_act = '0; IR = ~base_act;
    repeat (5) @(negedge CLK);

    // start and stop together in idle do nothing (fault stays as it was).
    start = 1'b1; stop = 1'b1; dir_in = 1'b1;
    @(negedge CLK); start = 1'b0; stop = 1'b0;
    repeat (8) @(negedge CLK);
    check("ss_en", EN, 0);
    check("ss_busy", busy, 0);
    check("ss_fault", fault, 1);
    check("ss_steps", rises.size(), 0);

    for (int r = 0; r < 16; r++) begin
      mode = int'($urandom_range(0, 2));
      d    = 1'($urandom_range(0, 1));
      so   = (mode != 1) ? int'($urandom_range(5, 60)) : -1;
      lo   = (mode != 0) ? int'($urandom_range(8, 60)) : -1;
      oo   = (mode == 0) ? int'($urandom_range(8, 60)) : -1;
      mo   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 50)) : -1;
      do_run(d, so, lo, oo, mo);
    end

    // Reset while a step pulse is high.
    start = 1'b1; dir_in = 1'b1;
    @(negedge CLK); start = 1'b0;
    for (int i = 0; i < 40 && !STEP; i++) @(negedge CLK);
    check("step_seen", STEP, 1);
    #2 RSTn = 1'b0;
    #1;
    check("rmid_step", STEP, 0);
    check("rmid_en", EN, 0);
    check("rmid_pos", position, 0);
    check("rmid_busy", busy, 0);
    @(negedge CLK); RSTn = 1'b1;
    rises.delete();
    repeat (20) @(negedge CLK);
    check("post_steps", rises.size(), 0);
    check("post_en", EN, 0);
    check("post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
